program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 19 +
 rtl/program_loader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// Byte-stream handshake between a load source and the program loader.
// The source drives byte_valid/byte_data; the loader answers with byte_ready.
interface program_loader_if;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;

   modport master (
      output byte_valid,
      output byte_data,
      input  byte_ready
   );

   modport slave (
      input  byte_valid,
      input  byte_data,
      output byte_ready
   );
endinterface

// File: rtl/program_loader.sv
// Streams a length-prefixed program image into instruction memory
// while holding the CPU in reset until the load completes.
module program_loader #(
   parameter int MAX_WORDS = 32768
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   program_loader_if.slave    bs,
   output logic               rom_we,
   output logic [14:0]        rom_adr,
   output logic [15:0]        rom_data,
   output logic               cpu_hold,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [15:0]        word_count
);

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DAT_HI,
      DAT_LO,
      WRITE,
      DONE,
      ERR
   } state_t;

   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   state_t      state;
   state_t      state_nx;
   logic [7:0]  hi_q;
   logic        xfer;
   logic [15:0] n_rx;
   logic [15:0] wr_next;

   assign xfer    = bs.byte_valid & bs.byte_ready;
   assign n_rx    = {hi_q, bs.byte_data};
   assign wr_next = {1'b0, rom_adr} + 16'd1;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      bs.byte_ready = 1'b0;
      rom_we        = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      err           = 1'b0;
      cpu_hold      = 1'b1;
      unique case (state)
         IDLE: begin
            if (start) state_nx = LEN_HI;
         end
         LEN_HI: begin
            busy          = 1'b1;
            bs.byte_ready = 1'b1;
            if (xfer) state_nx = LEN_LO;
         end
         LEN_LO: begin
            busy          = 1'b1;
            bs.byte_ready = 1'b1;
            if (xfer) begin
               if (n_rx == 16'd0)             state_nx = DONE;
               else if ({1'b0, n_rx} > MAX_N) state_nx = ERR;
               else                           state_nx = DAT_HI;
            end
         end
         DAT_HI: begin
            busy          = 1'b1;
            bs.byte_ready = 1'b1;
            if (xfer) state_nx = DAT_LO;
         end
         DAT_LO: begin
            busy          = 1'b1;
            bs.byte_ready = 1'b1;
            if (xfer) state_nx = WRITE;
         end
         WRITE: begin
            busy   = 1'b1;
            rom_we = 1'b1;
            if (wr_next < word_count) state_nx = DAT_HI;
            else                      state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (start) state_nx = LEN_HI;
         end
         ERR: begin
            err = 1'b1;
            if (start) state_nx = LEN_HI;
         end
         default: state_nx = IDLE;
      endcase
   end

   // hi_q holds the count high byte first, then each data high byte
   always_ff @(posedge clk) begin
      if (reset) begin
         rom_adr    <= '0;
         rom_data   <= '0;
         word_count <= '0;
         hi_q       <= '0;
      end else begin
         unique case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  rom_adr    <= '0;
                  word_count <= '0;
               end
            end
            LEN_HI: if (xfer) hi_q <= bs.byte_data;
            LEN_LO: if (xfer) word_count <= n_rx;
            DAT_HI: if (xfer) hi_q <= bs.byte_data;
            DAT_LO: if (xfer) rom_data <= n_rx;
            WRITE:  rom_adr <= rom_adr + 15'd1;
            default: ;
         endcase
      end
   end

endmodule
